// File: rtl/sm3_pkg.sv
// Shared SM3 types, round constants and the boolean/permutation helpers used
// by the compression core and its round datapath.
package sm3_pkg;

  // Bit 31 of a word is the big-endian bit 0 (most significant).
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Working registers; field a occupies the most significant 32 bits.
  typedef struct packed {
    word_t a, b, c, d, e, f, g, h;
  } regs_t;

  localparam word_t T_LOW  = 32'h79cc4519;
  localparam word_t T_HIGH = 32'h7a879d8a;
  localparam logic [255:0] IV =
    256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

  function automatic word_t rotl(word_t x, logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  function automatic word_t p0(word_t x);
    return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
  endfunction

  function automatic word_t p1(word_t x);
    return x ^ rotl(x, 5'd15) ^ rotl(x, 5'd23);
  endfunction

  function automatic word_t ff_j(word_t x, word_t y, word_t z, logic hi);
    return hi ? ((x & y) | (x & z) | (y & z)) : (x ^ y ^ z);
  endfunction

  function automatic word_t gg_j(word_t x, word_t y, word_t z, logic hi);
    return hi ? ((x & y) | (~x & z)) : (x ^ y ^ z);
  endfunction

endpackage

// File: rtl/sm3_round.sv
// One combinational SM3 compression round j over the A..H working state.
module sm3_round
  import sm3_pkg::*;
(
  input  regs_t      s_i,
  input  word_t      w_i,
  input  word_t      wp_i,
  input  logic [5:0] j_i,
  output regs_t      s_o
);

  logic  hi;
  word_t a12, tj, ss1, ss2, tt1, tt2;

  always_comb begin
    hi  = (j_i >= 6'd16);
    a12 = rotl(s_i.a, 5'd12);
    tj  = hi ? T_HIGH : T_LOW;
    ss1 = rotl(a12 + s_i.e + rotl(tj, j_i[4:0]), 5'd7);
    ss2 = ss1 ^ a12;
    tt1 = ff_j(s_i.a, s_i.b, s_i.c, hi) + s_i.d + ss2 + wp_i;
    tt2 = gg_j(s_i.e, s_i.f, s_i.g, hi) + s_i.h + ss1 + w_i;
    s_o = '{a: tt1,   b: s_i.a, c: rotl(s_i.b, 5'd9),  d: s_i.c,
            e: p0(tt2), f: s_i.e, g: rotl(s_i.f, 5'd19), h: s_i.g};
  end

endmodule

// File: rtl/sm3_compress_core.sv
// Iterative SM3 CF engine: ROUNDS_PER_CYCLE chained rounds per clock over a
// 16-word sliding message window, result V(i+1) held until accepted.
module sm3_compress_core
  import sm3_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit CHAIN_XOR        = 1'b1
) (
  input  logic         input_clk,
  input  logic         input_rst_n,
  input  logic         input_valid,
  output logic         output_ready_in,
  input  logic [511:0] input_block,
  input  logic [255:0] input_v,
  output logic         output_valid,
  input  logic         input_ready_out,
  output logic [255:0] output_v,
  output logic         output_busy
);

  localparam int R = ROUNDS_PER_CYCLE;

  if (R != 1 && R != 2 && R != 4) begin : g_bad_rounds
    $error("sm3_compress_core: ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  state_t            state_q, state_d;
  logic [5:0]        j_q, j_d;
  regs_t             s_q, s_d, s_new;
  logic [15:0][31:0] win_q, win_d;      // win_q[0] holds W_j
  logic [255:0]      vsave_q, vsave_d, out_q, out_d, s_new_v;

  // Window extended by the R words that become visible after this cycle.
  word_t ext [16+R];

  always_comb begin
    for (int k = 0; k < 16; k++) ext[k] = win_q[k];
    for (int k = 0; k < R; k++)
      ext[16+k] = p1(ext[k] ^ ext[k+7] ^ rotl(ext[k+13], 5'd15))
                ^ rotl(ext[k+3], 5'd7) ^ ext[k+10];
  end

  for (genvar i = 0; i < R; i++) begin : g_rnd
    regs_t s_in, s_out;
    if (i == 0) begin : g_head
      assign s_in = s_q;
    end else begin : g_link
      assign s_in = g_rnd[i-1].s_out;
    end
    sm3_round u_round (
      .s_i  (s_in),
      .w_i  (ext[i]),
      .wp_i (ext[i] ^ ext[i+4]),
      .j_i  (j_q + 6'(i)),
      .s_o  (s_out)
    );
  end

  assign s_new   = g_rnd[R-1].s_out;
  assign s_new_v = s_new;

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    s_d     = s_q;
    win_d   = win_q;
    vsave_d = vsave_q;
    out_d   = out_q;
    case (state_q)
      IDLE: if (input_valid) begin
        for (int k = 0; k < 16; k++) win_d[k] = input_block[511-32*k -: 32];
        s_d     = input_v;
        vsave_d = input_v;
        j_d     = '0;
        state_d = RUN;
      end
      RUN: begin
        s_d = s_new;
        for (int k = 0; k < 16; k++) win_d[k] = ext[k+R];
        j_d = j_q + 6'(R);
        // Last group of rounds ends with round 63.
        if (j_q == 6'(64 - R)) begin
          out_d   = CHAIN_XOR ? (s_new_v ^ vsave_q) : s_new_v;
          state_d = DONE;
        end
      end
      DONE: if (input_ready_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge input_clk or negedge input_rst_n) begin
    if (!input_rst_n) begin
      state_q <= IDLE;
      j_q     <= '0;
      s_q     <= '0;
      win_q   <= '0;
      vsave_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      s_q     <= s_d;
      win_q   <= win_d;
      vsave_q <= vsave_d;
      out_q   <= out_d;
    end
  end

  assign output_ready_in = (state_q == IDLE);
  assign output_valid    = (state_q == DONE);
  assign output_busy     = (state_q != IDLE);
  assign output_v        = out_q;

endmodule

// File: tb/tb_sm3_compress_core.sv
// Bench for sm3_compress_core: four instances (R=1,2,4 and R=1 without the
// chaining XOR) checked against a plain-arithmetic SM3 CF model.
module tb_sm3_compress_core;

  localparam logic [255:0] IV =
    256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
  localparam logic [511:0] ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] KAT   =
    256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
  localparam logic [511:0] ABCD1 = {16{32'h61626364}};
  localparam logic [511:0] PAD2  = {32'h80000000, 448'h0, 32'h00000200};
  localparam logic [255:0] DIG2  =
    256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         vld     [4];
  logic         rdy_in  [4];
  logic [511:0] ib      [4];
  logic [255:0] iv      [4];
  logic         ov      [4];
  logic         rdy_out [4];
  logic [255:0] ovv     [4];
  logic         busy    [4];
  logic [255:0] exp_v   [4];
  int           lat_c   [4] = '{64, 32, 16, 64};

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  sm3_compress_core #(.ROUNDS_PER_CYCLE(1), .CHAIN_XOR(1'b1)) u_r1 (
    .input_clk(clk), .input_rst_n(rst_n), .input_valid(vld[0]), .output_ready_in(rdy_in[0]),
    .input_block(ib[0]), .input_v(iv[0]), .output_valid(ov[0]), .input_ready_out(rdy_out[0]),
    .output_v(ovv[0]), .output_busy(busy[0]));
  sm3_compress_core #(.ROUNDS_PER_CYCLE(2), .CHAIN_XOR(1'b1)) u_r2 (
    .input_clk(clk), .input_rst_n(rst_n), .input_valid(vld[1]), .output_ready_in(rdy_in[1]),
    .input_block(ib[1]), .input_v(iv[1]), .output_valid(ov[1]), .input_ready_out(rdy_out[1]),
    .output_v(ovv[1]), .output_busy(busy[1]));
  sm3_compress_core #(.ROUNDS_PER_CYCLE(4), .CHAIN_XOR(1'b1)) u_r4 (
    .input_clk(clk), .input_rst_n(rst_n), .input_valid(vld[2]), .output_ready_in(rdy_in[2]),
    .input_block(ib[2]), .input_v(iv[2]), .output_valid(ov[2]), .input_ready_out(rdy_out[2]),
    .output_v(ovv[2]), .output_busy(busy[2]));
  sm3_compress_core #(.ROUNDS_PER_CYCLE(1), .CHAIN_XOR(1'b0)) u_nx (
    .input_clk(clk), .input_rst_n(rst_n), .input_valid(vld[3]), .output_ready_in(rdy_in[3]),
    .input_block(ib[3]), .input_v(iv[3]), .output_valid(ov[3]), .input_ready_out(rdy_out[3]),
    .output_v(ovv[3]), .output_busy(busy[3]));

  function automatic logic [31:0] rl(logic [31:0] x, int n);
    int m = n % 32;
    return (m == 0) ? x : ((x << m) | (x >> (32 - m)));
  endfunction

  // Textbook CF: full W[0..67] / W'[0..63] expansion, then 64 rounds.
  function automatic logic [255:0] sm3_cf(logic [255:0] v, logic [511:0] b, bit xr);
    logic [31:0] w [68];
    logic [31:0] wp [64];
    logic [31:0] r [8];
    logic [31:0] t, ss1, ss2, tt1, tt2, ff, gg, x;
    logic [255:0] o;
    for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
    for (int i = 16; i < 68; i++) begin
      x = w[i-16] ^ w[i-9] ^ rl(w[i-3], 15);
      w[i] = (x ^ rl(x, 15) ^ rl(x, 23)) ^ rl(w[i-13], 7) ^ w[i-6];
    end
    for (int i = 0; i < 64; i++) wp[i] = w[i] ^ w[i+4];
    for (int i = 0; i < 8; i++) r[i] = v[255-32*i -: 32];
    for (int j = 0; j < 64; j++) begin
      t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
      ss1 = rl(rl(r[0], 12) + r[4] + rl(t, j), 7);
      ss2 = ss1 ^ rl(r[0], 12);
      ff  = (j < 16) ? (r[0] ^ r[1] ^ r[2]) : ((r[0] & r[1]) | (r[0] & r[2]) | (r[1] & r[2]));
      gg  = (j < 16) ? (r[4] ^ r[5] ^ r[6]) : ((r[4] & r[5]) | (~r[4] & r[6]));
      tt1 = ff + r[3] + ss2 + wp[j];
      tt2 = gg + r[7] + ss1 + w[j];
      r[3] = r[2]; r[2] = rl(r[1], 9); r[1] = r[0]; r[0] = tt1;
      r[7] = r[6]; r[6] = rl(r[5], 19); r[5] = r[4];
      r[4] = tt2 ^ rl(tt2, 9) ^ rl(tt2, 17);
    end
    o = {r[0], r[1], r[2], r[3], r[4], r[5], r[6], r[7]};
    return xr ? (o ^ v) : o;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
    vectors++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, expv);
    end
  endtask

  // Result check on every cycle an instance presents a result.
  always @(negedge clk) begin
    if (rst_n === 1'b1)
      for (int k = 0; k < 4; k++)
        if (ov[k] === 1'b1) chk($sformatf("cmp%0d", k), ovv[k], exp_v[k]);
  end

  task automatic run_blk(input int k, input logic [511:0] blk, input logic [255:0] vin,
                         input logic [255:0] expv, input string nm, input bit bp,
                         input bit pulse, output logic [255:0] res);
    int cnt;
    logic [255:0] held;
    @(posedge clk); #1;
    chk({nm, "_rdy_in"}, 256'(rdy_in[k]), 256'd1);
    exp_v[k] = expv; ib[k] = blk; iv[k] = vin; vld[k] = 1'b1; rdy_out[k] = !bp;
    @(posedge clk); #1;
    vld[k] = 1'b0;
    cnt = 0;
    while (ov[k] !== 1'b1 && cnt < 300) begin
      if (pulse && cnt == 3) begin vld[k] = 1'b1; ib[k] = ~blk; iv[k] = ~vin; end
      if (pulse && cnt == 6) vld[k] = 1'b0;
      @(posedge clk); #1;
      cnt++;
    end
    chk({nm, "_latency"}, 256'(cnt), 256'(lat_c[k]));
    chk({nm, "_result"}, ovv[k], expv);
    chk({nm, "_busy"}, 256'(busy[k]), 256'd1);
    chk({nm, "_rdy_in_done"}, 256'(rdy_in[k]), 256'd0);
    res = ovv[k];
    if (bp) begin
      held = ovv[k];
      repeat (10) begin
        @(posedge clk); #1;
        chk({nm, "_bp_valid"}, 256'(ov[k]), 256'd1);
        chk({nm, "_bp_hold"}, ovv[k], held);
        chk({nm, "_bp_rdy_in"}, 256'(rdy_in[k]), 256'd0);
      end
      rdy_out[k] = 1'b1;
    end
    @(posedge clk); #1;
    chk({nm, "_valid_drop"}, 256'(ov[k]), 256'd0);
    chk({nm, "_idle_rdy"}, 256'(rdy_in[k]), 256'd1);
    chk({nm, "_idle_busy"}, 256'(busy[k]), 256'd0);
  endtask

  initial begin
    logic [255:0] r1, r2;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vld[k] = 1'b0; ib[k] = '0; iv[k] = '0; rdy_out[k] = 1'b1; exp_v[k] = '0;
    end
    #12;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_rdy%0d", k), 256'(rdy_in[k]), 256'd1);
      chk($sformatf("rst_valid%0d", k), 256'(ov[k]), 256'd0);
      chk($sformatf("rst_busy%0d", k), 256'(busy[k]), 256'd0);
      chk($sformatf("rst_v%0d", k), ovv[k], 256'd0);
    end
    @(negedge clk); rst_n = 1'b1;

    // Pin the model against published digests.
    chk("model_abc", sm3_cf(IV, ABC, 1'b1), KAT);
    chk("model_2blk", sm3_cf(sm3_cf(IV, ABCD1, 1'b1), PAD2, 1'b1), DIG2);

    run_blk(0, ABC, IV, KAT, "abc_r1", 1'b0, 1'b0, r1);
    run_blk(1, ABC, IV, KAT, "abc_r2", 1'b0, 1'b0, r1);
    run_blk(2, ABC, IV, KAT, "abc_r4", 1'b0, 1'b0, r1);

    run_blk(3, ABC, IV, sm3_cf(IV, ABC, 1'b0), "abc_raw", 1'b0, 1'b0, r1);
    chk("abc_raw_lit", r1, KAT ^ IV);

    run_blk(2, ABCD1, IV, sm3_cf(IV, ABCD1, 1'b1), "blk1_r4", 1'b0, 1'b0, r1);
    run_blk(2, PAD2, r1, sm3_cf(r1, PAD2, 1'b1), "blk2_r4", 1'b0, 1'b0, r2);
    chk("two_block_digest", r2, DIG2);

    run_blk(1, ABC, IV, KAT, "bp_r2", 1'b1, 1'b0, r1);
    run_blk(2, ABC, IV, KAT, "pulse_r4", 1'b0, 1'b1, r1);

    // Abort at j=30 on the R=1 instance.
    @(posedge clk); #1;
    exp_v[0] = KAT; ib[0] = ABC; iv[0] = IV; vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    repeat (30) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_valid", 256'(ov[0]), 256'd0);
    chk("abort_v", ovv[0], 256'd0);
    chk("abort_busy", 256'(busy[0]), 256'd0);
    chk("abort_rdy", 256'(rdy_in[0]), 256'd1);
    #20;
    @(negedge clk); rst_n = 1'b1;
    run_blk(0, ABC, IV, KAT, "after_abort", 1'b0, 1'b0, r1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
